mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage of the MIPS datapath, directly upstream of the 64-entry synchronous RAM. It accepts byte, halfword and word load/store requests on a byte address, and drives the RAM's address, write-data and write-enable pins. It consumes the RAM's registered read data and returns sign- or zero-extended load results. The RAM has no byte enables, so sub-word stores are done as read-modify-write.

## Interface
- BIT_WIDTH, 32, RAM word width; only 32 is supported.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request is accepted in the cycle where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends; ignored for word loads.
- req_addr  in  8  byte address; [7:2] selects the word, [1:0] selects the lane.
- req_wdata  in  32  store data, right-justified (the byte is in [7:0], the half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; the consumer cannot stall it.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  the request was misaligned or illegal, valid with resp_valid.
- ram_addr  out  6  RAM word address.
- ram_data  out  32  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  32  RAM read data, valid one cycle after ram_addr is presented.

## Operation
- All request fields are captured into registers on accept. RAM-side outputs are driven only from registers and state, with no combinational path from req_* to ram_*.
- Little-endian lane mapping:
  - Byte lane k occupies bits [8k+7:8k].
  - A halfword at addr[1]=h occupies bits [16h+15:16h].
- Error conditions: size 3, a halfword with addr[0]=1, or a word with addr[1:0]≠0. An error request performs no RAM access and returns resp_err=1 with resp_rdata=0.
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP. Transitions:
  - Error request: IDLE → RESP.
  - Word store: IDLE → WRITE → RESP.
  - Load: IDLE → READ → CAPTURE → RESP.
  - Sub-word store: IDLE → READ → CAPTURE → WRITE → RESP.
  - RESP → IDLE, always.
- READ: ram_addr = captured addr[7:2], ram_wren=0.
- CAPTURE:
  - Load: ram_q is lane-selected, extended and registered into resp_rdata.
  - Sub-word store: ram_q is registered into a merge buffer, with only the target lane(s) replaced by req_wdata[7:0] or [15:0].
- WRITE: ram_wren=1 for exactly this one cycle.
  - ram_data = req_wdata for a word store, or the merge buffer for a sub-word store.
  - ram_addr is unchanged from READ.
- ram_addr holds its value from READ or WRITE through RESP, and changes only when a new request is accepted.
- Reset values:
  - State is IDLE, so req_ready=1 once reset_n is high.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - ram_wren=0, ram_addr=0, ram_data=0.
- Reset asserted mid-operation aborts the request immediately and asynchronously. No response is issued, and no RAM write occurs unless the WRITE cycle's edge has already passed.

## Timing
- The accept cycle is cycle 0. resp_valid is high in:
  - cycle 1 for an error request;
  - cycle 2 for a word store (ram_wren high in cycle 1);
  - cycle 3 for a load (READ in cycle 1, ram_q sampled at the end of cycle 2);
  - cycle 4 for a sub-word store (READ 1, CAPTURE 2, WRITE 3).
- req_ready is low from cycle 1 through the RESP cycle. The next accept is possible in the cycle after RESP.
- Throughput is one request every 2, 3, 4 or 5 cycles, by class (error, word store, load, sub-word store).
- resp_rdata and resp_err are valid only during resp_valid, and are held until the next RESP.
- Holding req_valid high across a busy period does not duplicate a request: exactly one accept occurs per IDLE cycle.

## Test plan
- Word store, then load: store 0xDEADBEEF to addr 0x10, then load a word from 0x10.
  - The store shows ram_wren=1 with ram_addr=4 in cycle 1 and resp_valid in cycle 2.
  - The load returns 0xDEADBEEF with resp_valid in cycle 3.
- Byte read-modify-write: RAM word 2 = 0x11223344; store byte 0xAA at addr 0x09.
  - The write shows ram_data=0x1122AA44 in cycle 3 and resp_valid in cycle 4.
  - Signed byte load at 0x09 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Halfword: store 0x8001 at addr 0x0E (word 3 initially 0), then load.
  - RAM word 3 becomes 0x80010000.
  - Signed halfword load returns 0xFFFF8001; unsigned returns 0x00008001.
- Errors: a word load at 0x05, a halfword store at 0x03, and size=3.
  - Each gives resp_err=1 and resp_rdata=0 in cycle 1, with ram_wren never asserted.
- Back-to-back: hold req_valid high with four queued requests.
  - Each request is accepted only in IDLE.
  - resp_valid pulses once per request at the latencies above.
- Reset mid sub-word store: pull reset_n low in cycle 2 (CAPTURE).
  - ram_wren stays 0, the RAM word is unchanged, and no resp_valid is issued.
  - All outputs read their reset values; req_ready=1 after reset_n is released.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access stage sitting in front of a 64-entry synchronous RAM
// that has no byte enables. Byte/halfword/word loads and stores are issued
// on a byte address; sub-word stores are performed as read-modify-write.
//
// Ports
//   clock, reset_n          clock and asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write               1 = store, 0 = load
//   req_size                0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed              sign-extend sub-word loads
//   req_addr                byte address ([7:2] word, [1:0] lane)
//   req_wdata               right-justified store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    load result / error flag, held until next response
//   ram_addr, ram_data,
//   ram_wren                registered RAM pins
//   ram_q                   RAM read data, one cycle after ram_addr
module mem_access_unit #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [7:0]           req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [5:0]           ram_addr,
    output logic [BIT_WIDTH-1:0] ram_data,
    output logic                 ram_wren,
    input  logic [BIT_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                 r_state;
    logic                   r_write;
    logic [1:0]             r_size;
    logic                   r_signed;
    logic [1:0]             r_lane;
    logic [15:0]            r_wdata;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic [BIT_WIDTH-1:0]   r_resp_rdata;
    logic [5:0]             r_ram_addr;
    logic [BIT_WIDTH-1:0]   r_ram_data;
    logic                   r_ram_wren;

    // Illegal size or an address not aligned to the access size.
    function automatic logic is_err(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'd3) ||
               (size == 2'd1 && lane[0]) ||
               (size == 2'd2 && lane != 2'd0);
    endfunction

    // Lane-select and extend a load. Aligned halfwords always have lane[0]=0,
    // so a shift by lane*8 serves both byte and halfword; words have lane 0.
    function automatic logic [BIT_WIDTH-1:0] load_extract(
        input logic [BIT_WIDTH-1:0] q,
        input logic [1:0]           size,
        input logic [1:0]           lane,
        input logic                 sgn
    );
        logic [BIT_WIDTH-1:0] sh;
        sh = q >> {lane, 3'b000};
        case (size)
            2'd0:    return {{(BIT_WIDTH-8){sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{(BIT_WIDTH-16){sgn & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Replace only the target lane(s) of the old RAM word.
    function automatic logic [BIT_WIDTH-1:0] store_merge(
        input logic [BIT_WIDTH-1:0] q,
        input logic [1:0]           size,
        input logic [1:0]           lane,
        input logic [15:0]          wd
    );
        logic [BIT_WIDTH-1:0] m;
        m = q;
        if (size == 2'd0)
            m[{lane, 3'b000} +: 8] = wd[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = wd;
        return m;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_lane       <= 2'd0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_ram_wren   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        if (is_err(req_size, req_addr[1:0])) begin
                            // No RAM access: respond on the next cycle.
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= S_RESP;
                        end else begin
                            r_ram_addr <= req_addr[7:2];
                            if (req_write && req_size == 2'd2) begin
                                // Full word store needs no read.
                                r_ram_data <= req_wdata;
                                r_ram_wren <= 1'b1;
                                r_state    <= S_WRITE;
                            end else begin
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (r_write) begin
                        r_ram_data <= store_merge(ram_q, r_size, r_lane, r_wdata);
                        r_ram_wren <= 1'b1;
                        r_state    <= S_WRITE;
                    end else begin
                        r_resp_rdata <= load_extract(ram_q, r_size, r_lane, r_signed);
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_ram_wren   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign ram_wren   = r_ram_wren;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    logic [31:0] mem [64];

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.BIT_WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    // Synchronous RAM with registered read data.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One isolated request starting in an idle cycle. lat = response cycle,
    // wren_cyc = cycle with ram_wren high (0 = none).
    task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [7:0] ad, input logic [31:0] wd,
                        input int lat, input int wren_cyc, input logic [31:0] exp_rd,
                        input logic exp_err, input logic [31:0] exp_wdata);
        chk($sformatf("%s ready c0", tag), req_ready, 1);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            chk($sformatf("%s ready c%0d", tag, c), req_ready, 0);
            chk($sformatf("%s resp_valid c%0d", tag, c), resp_valid, (c == lat));
            chk($sformatf("%s ram_wren c%0d", tag, c), ram_wren, (c == wren_cyc));
            if (c == wren_cyc) begin
                chk($sformatf("%s ram_addr", tag), ram_addr, ad[7:2]);
                chk($sformatf("%s ram_data", tag), ram_data, exp_wdata);
            end
            if (c == lat) begin
                chk($sformatf("%s rdata", tag), resp_rdata, exp_rd);
                chk($sformatf("%s err", tag), resp_err, exp_err);
            end
            if (c < lat) step();
        end
        step();
        chk($sformatf("%s resp_valid after", tag), resp_valid, 0);
        chk($sformatf("%s ram_wren after", tag), ram_wren, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [7:0]  ad;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic        err;
    } req_t;

    req_t rq [4];
    int   acc [4];
    int   rsp [4];

    task automatic apply(input req_t r);
        req_write  = r.wr;
        req_size   = r.sz;
        req_signed = r.sg;
        req_addr   = r.ad;
        req_wdata  = r.wd;
    endtask

    initial begin
        int  ai;
        int  ri;
        logic accepted;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        step();
        step();
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_err", resp_err, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst ram_wren", ram_wren, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_data", ram_data, 0);
        reset_n = 1'b1;
        step();
        chk("rst req_ready", req_ready, 1);

        // Word store then word load.
        xact("wst", 1, 2'd2, 0, 8'h10, 32'hDEADBEEF, 2, 1, 32'h0, 0, 32'hDEADBEEF);
        chk("wst mem4", mem[4], 32'hDEADBEEF);
        xact("wld", 0, 2'd2, 1, 8'h10, 32'h0, 3, 0, 32'hDEADBEEF, 0, 32'h0);

        // Byte read-modify-write on word 2.
        xact("pre2", 1, 2'd2, 0, 8'h08, 32'h11223344, 2, 1, 32'h0, 0, 32'h11223344);
        xact("bst", 1, 2'd0, 0, 8'h09, 32'h000000AA, 4, 3, 32'h0, 0, 32'h1122AA44);
        chk("bst mem2", mem[2], 32'h1122AA44);
        xact("lbs", 0, 2'd0, 1, 8'h09, 32'h0, 3, 0, 32'hFFFFFFAA, 0, 32'h0);
        xact("lbu", 0, 2'd0, 0, 8'h09, 32'h0, 3, 0, 32'h000000AA, 0, 32'h0);
        xact("lb3", 0, 2'd0, 0, 8'h0B, 32'h0, 3, 0, 32'h00000011, 0, 32'h0);

        // Halfword store into upper half of word 3.
        xact("pre3", 1, 2'd2, 0, 8'h0C, 32'h00000000, 2, 1, 32'h0, 0, 32'h0);
        xact("hst", 1, 2'd1, 0, 8'h0E, 32'h00008001, 4, 3, 32'h0, 0, 32'h80010000);
        chk("hst mem3", mem[3], 32'h80010000);
        xact("lhs", 0, 2'd1, 1, 8'h0E, 32'h0, 3, 0, 32'hFFFF8001, 0, 32'h0);
        xact("lhu", 0, 2'd1, 0, 8'h0E, 32'h0, 3, 0, 32'h00008001, 0, 32'h0);
        xact("lhlo", 0, 2'd1, 1, 8'h0C, 32'h0, 3, 0, 32'h00000000, 0, 32'h0);

        // Error requests.
        xact("err wld05", 0, 2'd2, 0, 8'h05, 32'h0, 1, 0, 32'h0, 1, 32'h0);
        xact("err hst03", 1, 2'd1, 0, 8'h03, 32'h0000FFFF, 1, 0, 32'h0, 1, 32'h0);
        xact("err size3", 0, 2'd3, 0, 8'h00, 32'h0, 1, 0, 32'h0, 1, 32'h0);
        chk("err mem0 untouched", mem[0], 32'hxxxxxxxx);

        // Back-to-back with req_valid held high.
        rq[0] = '{1'b1, 2'd2, 1'b0, 8'h20, 32'h0BADF00D, 2, 32'h0, 1'b0};
        rq[1] = '{1'b0, 2'd2, 1'b0, 8'h20, 32'h0,        3, 32'h0BADF00D, 1'b0};
        rq[2] = '{1'b0, 2'd3, 1'b0, 8'h20, 32'h0,        1, 32'h0, 1'b1};
        rq[3] = '{1'b1, 2'd0, 1'b0, 8'h21, 32'h00000055, 4, 32'h0, 1'b0};
        ai = 0;
        ri = 0;
        apply(rq[0]);
        req_valid = 1'b1;
        for (int t = 0; t < 60 && ri < 4; t++) begin
            accepted = 1'b0;
            if (resp_valid) begin
                rsp[ri] = t;
                chk($sformatf("b2b rdata %0d", ri), resp_rdata, rq[ri].rd);
                chk($sformatf("b2b err %0d", ri), resp_err, rq[ri].err);
                ri++;
            end
            if (ai < 4 && req_ready && req_valid) begin
                acc[ai] = t;
                ai++;
                accepted = 1'b1;
            end
            step();
            if (accepted) begin
                if (ai < 4) apply(rq[ai]);
                else req_valid = 1'b0;
            end
        end
        chk("b2b accepts", ai, 4);
        chk("b2b responses", ri, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ri && i < ai) begin
                chk($sformatf("b2b latency %0d", i), rsp[i] - acc[i], rq[i].lat);
                if (i > 0)
                    chk($sformatf("b2b accept gap %0d", i), acc[i], rsp[i-1] + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("b2b no extra resp", resp_valid, 0);
            step();
        end
        chk("b2b mem8", mem[8], 32'h0BAD550D);

        // Reset during CAPTURE of a byte store.
        xact("pre5", 1, 2'd2, 0, 8'h14, 32'hCAFEBABE, 2, 1, 32'h0, 0, 32'hCAFEBABE);
        req_write  = 1'b1;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 8'h14;
        req_wdata  = 32'h00000077;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("mid rst resp_valid", resp_valid, 0);
        chk("mid rst resp_err", resp_err, 0);
        chk("mid rst resp_rdata", resp_rdata, 0);
        chk("mid rst ram_wren", ram_wren, 0);
        chk("mid rst ram_addr", ram_addr, 0);
        chk("mid rst ram_data", ram_data, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid rst wren held", ram_wren, 0);
            chk("mid rst no resp", resp_valid, 0);
        end
        reset_n = 1'b1;
        #1;
        chk("mid rst ready", req_ready, 1);
        chk("mid rst mem5", mem[5], 32'hCAFEBABE);
        step();
        xact("post rst lw", 0, 2'd2, 0, 8'h14, 32'h0, 3, 0, 32'hCAFEBABE, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
